// File: rtl/div_pkg.sv
// Shared types and width constants for the unsigned sequential divider.
package div_pkg;

  localparam int W_DEF       = 8;
  localparam int TRUNC_L_DEF = 2;
  localparam int DVD_W_DEF   = 2 * W_DEF;
  localparam int CNT_W_DEF   = $clog2(DVD_W_DEF);

  // Quotient reported for a zero divisor at the default width.
  localparam logic [DVD_W_DEF-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for a given divisor width.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_restore_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in W+1 bits and bit W+1 of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Iterative restoring divider: 2*W-bit dividend / W-bit divisor, one quotient
// bit per cycle, valid/ready handshake on both sides.
// Build option APPROX_DIV_EN: skip the TRUNC_L lowest quotient bits (forced
// to zero) and report a zero remainder.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one restoring step per cycle, counter counts down to 0
// DONE  | result registered on the first cycle, then held with out_valid
module unsigned_seq_divider_16by8
  import div_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TRUNC_L = TRUNC_L_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int DW = 2 * W;
  localparam int CW = cnt_width(W);

`ifdef APPROX_DIV_EN
  localparam int TRUNC_EFF = TRUNC_L;
`else
  // Exact build: every quotient bit is computed whatever TRUNC_L says.
  localparam int TRUNC_EFF = 0 * TRUNC_L;
`endif

  localparam logic [CW-1:0] CNT_START = CW'(DW - TRUNC_EFF - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     rem_q;
  logic [DW-1:0]  dvd_q;
  logic [W-1:0]   dvs_q;
  logic           dbz_q;

  logic [W:0]     step_rem;
  logic           step_q;
  logic [DW-1:0]  q_res;
  logic [W-1:0]   r_res;

  div_restore_step #(.W(W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DW-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Result formatting; in the approximate build the remaining dividend bits
  // above the computed quotient bits are shifted out.
  always_comb begin
    q_res = dbz_q ? dvd_q : (dvd_q << TRUNC_EFF);
`ifdef APPROX_DIV_EN
    r_res = dbz_q ? rem_q[W-1:0] : '0;
`else
    r_res = rem_q[W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and request-side ready.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvs_q       <= divisor;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              dbz_q <= 1'b1;
              dvd_q <= {DW{1'b1}};
              rem_q <= {1'b0, dividend[W-1:0]};
              cnt_q <= '0;
            end else begin
              dbz_q <= 1'b0;
              dvd_q <= dividend;
              rem_q <= '0;
              cnt_q <= CNT_START;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[DW-2:0], step_q};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= dbz_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Scoreboard bench for the sequential divider: expected results are queued
// at request time and compared when the divider presents its result.
module tb_unsigned_seq_divider_16by8;

  localparam int W = 8;
`ifdef APPROX_DIV_EN
  localparam int TRUNC = 2;
`else
  localparam int TRUNC = 0;
`endif
  localparam int LAT = 2 * W + 1 - TRUNC;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  unsigned_seq_divider_16by8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef APPROX_DIV_EN
      e.q = e.q & 16'hFFFC;
      e.r = 8'd0;
`endif
      e.dbz = 1'b0; e.lat = LAT;
    end
    return e;
  endfunction

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    chk("in_ready_at_send", in_ready, 1);
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int lat_exp, output bit ok);
    int lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    ok = out_valid;
    if (!ok) chk("timeout", 0, 1);
    else     chk("latency", lat, lat_exp);
  endtask

  // Compare the held result against the scoreboard, then hand it off.
  task automatic take();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.dbz);
    chk("in_ready_busy", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b);
    bit ok;
    send(a, b);
    wait_out(sb[sb.size()-1].lat, ok);
    if (ok) take();
    else void'(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    run(16'd700, 8'd7);
    run(16'd65535, 8'd255);
    run(16'd1000, 8'd3);
    run(16'h1234, 8'd0);
    run(16'd700, 8'd7);
    run(16'd5, 8'd200);
    run(16'd65535, 8'd1);
    run(16'd0, 8'd9);

    // Backpressure with a competing request that must be ignored.
    send(16'd1000, 8'd3);
    wait_out(LAT, ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'd50; divisor = 8'd1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_quotient", quotient, sb[0].q);
        chk("bp_remainder", remainder, sb[0].r);
      end
      in_valid = 1'b0;
      take();
      repeat (3) begin
        @(negedge clk);
        chk("no_phantom", out_valid, 0);
      end
    end else void'(sb.pop_front());

    // Reset during CALC discards the pending result.
    send(16'd1000, 8'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run(16'd700, 8'd7);

    for (int i = 0; i < 8; i++)
      run(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
